// File: rtl/cla4_adder.sv
// Registered two-level carry-lookahead adder built from 4-bit lookahead groups.
// Optional `CLA_OVF_EN adds a registered two's-complement overflow output (ovf).
module cla4_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
`ifdef CLA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NG = WIDTH / 4;

    if (((WIDTH % 4) != 0) || (WIDTH < 4) || (WIDTH > 32)) begin : g_width_check
        $error("cla4_adder: WIDTH must be a multiple of 4 in the range 4..32");
    end

    // Carries c1..c3 of one 4-bit group, flattened lookahead form.
    function automatic logic [2:0] group_inner_carries(
        input logic [2:0] p,
        input logic [2:0] g,
        input logic       c0
    );
        logic c1;
        logic c2;
        logic c3;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return {c3, c2, c1};
    endfunction

    // Carry c4 out of one 4-bit group; with c0 = 0 this is the group generate.
    function automatic logic group_carry_out(
        input logic [3:0] p,
        input logic [3:0] g,
        input logic       c0
    );
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
    endfunction

    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] g_s;
    logic [NG-1:0]    grp_p_s;
    logic [NG-1:0]    grp_g_s;
    logic [NG:0]      grp_c_s;
    logic [WIDTH-1:0] carry_s;
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    assign p_s    = a ^ b;
    assign g_s    = a & b;
    assign sum_s  = p_s ^ carry_s;
    assign cout_s = grp_c_s[NG];

    // Group propagate/generate for the second lookahead level.
    always_comb begin
        grp_p_s = '0;
        grp_g_s = '0;
        for (int j = 0; j < NG; j++) begin
            grp_p_s[j] = &p_s[4*j +: 4];
            grp_g_s[j] = group_carry_out(p_s[4*j +: 4], g_s[4*j +: 4], 1'b0);
        end
    end

    // Second-level lookahead: each group carry is a flat sum of products of group P/G and cin.
    always_comb begin
        logic acc_v;
        logic term_v;
        acc_v      = 1'b0;
        term_v     = 1'b0;
        grp_c_s    = '0;
        grp_c_s[0] = cin;
        for (int j = 1; j <= NG; j++) begin
            acc_v = 1'b0;
            for (int k = 0; k < j; k++) begin
                term_v = grp_g_s[k];
                for (int m = k + 1; m < j; m++) begin
                    term_v = term_v & grp_p_s[m];
                end
                acc_v = acc_v | term_v;
            end
            term_v = cin;
            for (int m = 0; m < j; m++) begin
                term_v = term_v & grp_p_s[m];
            end
            grp_c_s[j] = acc_v | term_v;
        end
    end

    // Bit carries inside each group, seeded by that group's lookahead carry-in.
    always_comb begin
        carry_s = '0;
        for (int j = 0; j < NG; j++) begin
            carry_s[4*j]       = grp_c_s[j];
            carry_s[4*j+1 +: 3] = group_inner_carries(p_s[4*j +: 3], g_s[4*j +: 3], grp_c_s[j]);
        end
    end

`ifdef CLA_OVF_EN
    logic ovf_s;
    logic ovf_r;

    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    always_comb begin
        ovf_s = carry_s[WIDTH-1] ^ cout_s;
    end

    // Overflow flag registered alongside the sum; holds while in_valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (in_valid) begin
            ovf_r <= ovf_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`endif

    // Result registers: reset wins, sum/cout load only on in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                sum_r  <= sum_s;
                cout_r <= cout_s;
            end else begin
                sum_r  <= sum_r;
                cout_r <= cout_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_cla4_adder.sv
// Self-checking bench for cla4_adder: WIDTH=4 and WIDTH=16 instances against an arithmetic model.
// With CLA_OVF_EN defined the ovf outputs are checked as well.
module tb_cla4_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        out_valid4;
    logic [3:0]  sum4;
    logic        cout4;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cin16;
    logic        out_valid16;
    logic [15:0] sum16;
    logic        cout16;
`ifdef CLA_OVF_EN
    logic        ovf4;
    logic        ovf16;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    // Reference model state (expected registered outputs)
    logic        m4_valid;
    logic [3:0]  m4_sum;
    logic        m4_cout;
    logic        m4_ovf;
    logic        m16_valid;
    logic [15:0] m16_sum;
    logic        m16_cout;
    logic        m16_ovf;

    cla4_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(out_valid4), .sum(sum4),
`ifdef CLA_OVF_EN
        .ovf(ovf4),
`endif
        .cout(cout4)
    );

    cla4_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a16), .b(b16), .cin(cin16),
        .out_valid(out_valid16), .sum(sum16),
`ifdef CLA_OVF_EN
        .ovf(ovf16),
`endif
        .cout(cout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
        return 33'(x) + 33'(y) + 33'(c);
    endfunction

    // Signed overflow from operand and result sign bits.
    function automatic logic ref_ovf(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the active edge
    always @(posedge clk) begin
        logic [32:0] r4;
        logic [32:0] r16;
        r4  = ref_add({28'd0, a4}, {28'd0, b4}, cin4);
        r16 = ref_add({16'd0, a16}, {16'd0, b16}, cin16);
        if (!rst_n) begin
            m4_valid  <= 1'b0; m4_sum  <= 4'd0;  m4_cout  <= 1'b0; m4_ovf  <= 1'b0;
            m16_valid <= 1'b0; m16_sum <= 16'd0; m16_cout <= 1'b0; m16_ovf <= 1'b0;
        end else begin
            m4_valid  <= in_valid;
            m16_valid <= in_valid;
            if (in_valid) begin
                m4_sum   <= r4[3:0];
                m4_cout  <= r4[4];
                m4_ovf   <= ref_ovf(a4[3], b4[3], r4[3]);
                m16_sum  <= r16[15:0];
                m16_cout <= r16[16];
                m16_ovf  <= ref_ovf(a16[15], b16[15], r16[15]);
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid4", {31'd0, out_valid4}, {31'd0, m4_valid});
            chk("sum4", {28'd0, sum4}, {28'd0, m4_sum});
            chk("cout4", {31'd0, cout4}, {31'd0, m4_cout});
            chk("valid16", {31'd0, out_valid16}, {31'd0, m16_valid});
            chk("sum16", {16'd0, sum16}, {16'd0, m16_sum});
            chk("cout16", {31'd0, cout16}, {31'd0, m16_cout});
`ifdef CLA_OVF_EN
            chk("ovf4", {31'd0, ovf4}, {31'd0, m4_ovf});
            chk("ovf16", {31'd0, ovf16}, {31'd0, m16_ovf});
`endif
        end
    end

    task automatic apply_both(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                              input logic [15:0] xv, input logic [15:0] yv, input logic zv,
                              input logic vv);
        a4 = av; b4 = bv; cin4 = cv;
        a16 = xv; b16 = yv; cin16 = zv;
        in_valid = vv;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] av, input logic [3:0] bv, input logic cv, input logic vv);
        apply_both(av, bv, cv, 16'($urandom), 16'($urandom), 1'($urandom), vv);
    endtask

    task automatic pin4(input string name, input logic [3:0] s, input logic c, input logic v);
        chk({name, "_sum"}, {28'd0, sum4}, {28'd0, s});
        chk({name, "_cout"}, {31'd0, cout4}, {31'd0, c});
        chk({name, "_valid"}, {31'd0, out_valid4}, {31'd0, v});
    endtask

    initial begin
        rst_n = 1'b0;
        // Reset held two cycles with live operands
        apply(4'b1111, 4'b1111, 1'b1, 1'b1);
        chk_en = 1'b1;
        apply(4'b1111, 4'b1111, 1'b1, 1'b1);
        pin4("reset", 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;

        apply(4'b0001, 4'b0010, 1'b0, 1'b1);
        pin4("basic", 4'b0011, 1'b0, 1'b1);
        apply(4'b1001, 4'b0110, 1'b0, 1'b1);
        pin4("full_nocarry", 4'b1111, 1'b0, 1'b1);
        apply(4'b1111, 4'b0001, 1'b0, 1'b1);
        pin4("wrap", 4'b0000, 1'b1, 1'b1);
        apply(4'b1111, 4'b0000, 1'b1, 1'b1);
        pin4("cin_chain", 4'b0000, 1'b1, 1'b1);
        apply(4'b1111, 4'b1111, 1'b1, 1'b1);
        pin4("max", 4'b1111, 1'b1, 1'b1);
        apply(4'b0011, 4'b0100, 1'b0, 1'b1);
        pin4("gate_load", 4'b0111, 1'b0, 1'b1);
        apply(4'b1010, 4'b0101, 1'b0, 1'b0);
        pin4("gate_hold", 4'b0111, 1'b0, 1'b0);

        apply(4'b0111, 4'b0001, 1'b0, 1'b1);
        pin4("signed_ovf", 4'b1000, 1'b0, 1'b1);
`ifdef CLA_OVF_EN
        chk("signed_ovf_ovf", {31'd0, ovf4}, 32'd1);
`endif

        apply_both(4'b0000, 4'b0000, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        chk("max16_sum", {16'd0, sum16}, 32'h0000_FFFF);
        chk("max16_cout", {31'd0, cout16}, 32'd1);
        apply_both(4'b0000, 4'b0000, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        chk("ovf16_sum", {16'd0, sum16}, 32'h0000_8000);
        chk("ovf16_cout", {31'd0, cout16}, 32'd0);
`ifdef CLA_OVF_EN
        chk("ovf16_ovf", {31'd0, ovf16}, 32'd1);
`endif

        // Reset in the middle of a stream discards the in-flight result
        rst_n = 1'b0;
        apply(4'b0101, 4'b0101, 1'b0, 1'b1);
        pin4("mid_reset", 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Exhaustive 4-bit sweep, back-to-back, random 16-bit alongside
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            apply(v[7:4], v[3:0], v[8], 1'b1);
        end
        apply(4'b0000, 4'b0000, 1'b0, 1'b0);
        apply(4'b0000, 4'b0000, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
